// File: rtl/dp_pkg.sv
// Shared opcode and sequencer-state encodings for param_seq_datapath.
package dp_pkg;

    localparam int unsigned OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 5'd0,
        OP_SUB  = 5'd1,
        OP_AND  = 5'd2,
        OP_OR   = 5'd3,
        OP_SHR  = 5'd4,
        OP_SHL  = 5'd5,
        OP_ROR  = 5'd6,
        OP_ROL  = 5'd7,
        OP_NEG  = 5'd8,
        OP_NOT  = 5'd9,
        OP_ADDI = 5'd10,
        OP_MUL  = 5'd11,
        OP_DIV  = 5'd12,
        OP_MFHI = 5'd13,
        OP_MFLO = 5'd14,
        OP_IN   = 5'd15,
        OP_OUT  = 5'd16,
        OP_LD   = 5'd17,
        OP_ST   = 5'd18
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T3,
        S_T4,
        S_DIVW,
        S_T5,
        S_T6,
        S_MEM,
        S_WB,
        S_FIN
    } state_e;

    // Opcodes are allocated densely from zero, so legality is a range check.
    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_ST;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, exactly W cycles after start.
module seq_divider #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     dvs;
    logic [W:0]       partial;
    logic             ge;
    logic [W-1:0]     next_rem;

    // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
    always_comb begin
        partial  = {remainder, quotient[W-1]};
        ge       = partial >= {1'b0, dvs};
        next_rem = ge ? (partial[W-1:0] - dvs) : partial[W-1:0];
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            cnt       <= '0;
            dvs       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quotient  <= dividend;
                remainder <= '0;
                dvs       <= divisor;
                cnt       <= CNT_W'(W);
                busy      <= 1'b1;
            end else if (busy) begin
                quotient  <= {quotient[W-2:0], ge};
                remainder <= next_rem;
                cnt       <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/param_seq_datapath.sv
// Bus datapath with GPR file, Y/Z/HI/LO/MAR/MDR and a command-level microstep sequencer.
module param_seq_datapath
    import dp_pkg::*;
#(
    parameter  int unsigned W      = 32,
    parameter  int unsigned N_REGS = 16,
    localparam int unsigned RIDX_W = $clog2(N_REGS)
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [RIDX_W-1:0] cmd_ra,
    input  logic [RIDX_W-1:0] cmd_rb,
    input  logic [RIDX_W-1:0] cmd_rc,
    input  logic [W-1:0]      cmd_imm,
    output logic              done,
    output logic              cmd_err,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [W-1:0]      mem_addr,
    output logic [W-1:0]      mem_wdata,
    input  logic [W-1:0]      mem_rdata,
    input  logic              mem_ack,
    input  logic [W-1:0]      inport_data,
    input  logic              inport_strobe,
    output logic [W-1:0]      outport_data,
    input  logic [RIDX_W-1:0] dbg_sel,
    output logic [W-1:0]      dbg_data
);

    localparam int unsigned SH_W = $clog2(W);

    state_e            state;
    logic [OP_W-1:0]   op_q;
    logic [RIDX_W-1:0] ra_q, rb_q, rc_q;
    logic [W-1:0]      imm_q;
    logic [W-1:0]      regs [N_REGS];
    logic [W-1:0]      y, hi, lo, mar, mdr, inport;
    logic [2*W-1:0]    z;

    logic [W-1:0]      base, opb, alu_res;
    logic [SH_W-1:0]   sh;
    logic [2*W-1:0]    rot_r, rot_l, prod;
    logic              div_start, div_busy, div_done;
    logic [W-1:0]      div_q, div_r;

    assign mem_addr  = mar;
    assign mem_wdata = mdr;
    assign dbg_data  = regs[dbg_sel];

    // R0 only reads as zero when used as an address/immediate base.
    assign base = (rb_q == '0) ? '0 : regs[rb_q];
    assign prod = {{W{1'b0}}, y} * {{W{1'b0}}, regs[rc_q]};

    always_comb begin
        opb     = (op_q == OP_ADDI) ? imm_q : regs[rc_q];
        sh      = opb[SH_W-1:0];
        rot_r   = {y, y} >> sh;
        rot_l   = {y, y} << sh;
        alu_res = '0;
        case (op_q)
            OP_ADD, OP_ADDI: alu_res = y + opb;
            OP_SUB:          alu_res = y - opb;
            OP_AND:          alu_res = y & opb;
            OP_OR:           alu_res = y | opb;
            OP_SHR:          alu_res = y >> sh;
            OP_SHL:          alu_res = y << sh;
            OP_ROR:          alu_res = rot_r[W-1:0];
            OP_ROL:          alu_res = rot_l[2*W-1:W];
            OP_NEG:          alu_res = '0 - y;
            OP_NOT:          alu_res = ~y;
            default:         alu_res = '0;
        endcase
    end

    assign div_start = (state == S_T4) && (op_q == OP_DIV) && !div_busy;

    seq_divider #(.W(W)) u_div (
        .clk       (clk),
        .clear     (clear),
        .start     (div_start),
        .dividend  (y),
        .divisor   (regs[rc_q]),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Input port capture is independent of the sequencer.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            inport <= '0;
        end else if (inport_strobe) begin
            inport <= inport_data;
        end
    end

    // Sequencer: every transfer and every handshake output is updated here.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state        <= S_IDLE;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            cmd_err      <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            op_q         <= '0;
            ra_q         <= '0;
            rb_q         <= '0;
            rc_q         <= '0;
            imm_q        <= '0;
            y            <= '0;
            z            <= '0;
            hi           <= '0;
            lo           <= '0;
            mar          <= '0;
            mdr          <= '0;
            outport_data <= '0;
            for (int unsigned i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done    <= 1'b0;
            cmd_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        ra_q      <= cmd_ra;
                        rb_q      <= cmd_rb;
                        rc_q      <= cmd_rc;
                        imm_q     <= cmd_imm;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_T3;
                    end
                end
                S_T3: begin
                    if (!op_legal(op_q)) begin
                        cmd_err <= 1'b1;
                        done    <= 1'b1;
                        state   <= S_FIN;
                    end else begin
                        case (op_q)
                            OP_MFHI, OP_MFLO, OP_IN, OP_OUT: begin
                                if (op_q == OP_MFHI) regs[ra_q] <= hi;
                                if (op_q == OP_MFLO) regs[ra_q] <= lo;
                                if (op_q == OP_IN)   regs[ra_q] <= inport;
                                if (op_q == OP_OUT)  outport_data <= regs[ra_q];
                                done  <= 1'b1;
                                state <= S_FIN;
                            end
                            OP_LD, OP_ST: begin
                                mar     <= base + imm_q;
                                if (op_q == OP_ST) mdr <= regs[ra_q];
                                mem_req <= 1'b1;
                                mem_we  <= (op_q == OP_ST);
                                state   <= S_MEM;
                            end
                            default: begin
                                y     <= (op_q == OP_ADDI) ? base : regs[rb_q];
                                state <= S_T4;
                            end
                        endcase
                    end
                end
                S_T4: begin
                    if (op_q == OP_MUL) begin
                        z     <= prod;
                        state <= S_T5;
                    end else if (op_q == OP_DIV) begin
                        state <= S_DIVW;
                    end else begin
                        z     <= {{W{1'b0}}, alu_res};
                        state <= S_T5;
                    end
                end
                S_DIVW: begin
                    if (div_done) begin
                        lo    <= div_q;
                        hi    <= div_r;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_T5: begin
                    if (op_q == OP_MUL) begin
                        lo    <= z[W-1:0];
                        state <= S_T6;
                    end else begin
                        regs[ra_q] <= z[W-1:0];
                        done       <= 1'b1;
                        state      <= S_FIN;
                    end
                end
                S_T6: begin
                    hi    <= z[2*W-1:W];
                    done  <= 1'b1;
                    state <= S_FIN;
                end
                S_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (op_q == OP_LD) begin
                            mdr   <= mem_rdata;
                            state <= S_WB;
                        end else begin
                            done  <= 1'b1;
                            state <= S_FIN;
                        end
                    end
                end
                S_WB: begin
                    regs[ra_q] <= mdr;
                    done       <= 1'b1;
                    state      <= S_FIN;
                end
                S_FIN: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
